// File: rtl/oram_pkg.sv
// Shared types and tree-walk helpers for the Path-ORAM responder.
package oram_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_POS,
        ST_READ,
        ST_ACCESS,
        ST_EVICT,
        ST_RESP
    } state_e;

    // 1-based heap index of the bucket at `level` on the path to `leaf`.
    function automatic logic [31:0] path_node(input logic [31:0] leaf, input int level, input int depth);
        return ((32'd1 << depth) + leaf) >> (depth - level);
    endfunction

    // True when both leaves share the same ancestor at `level`.
    function automatic logic on_path(input logic [31:0] leaf_a, input logic [31:0] leaf_b,
                                     input int level, input int depth);
        return (leaf_a >> (depth - level)) == (leaf_b >> (depth - level));
    endfunction

endpackage

// File: rtl/oram_lfsr.sv
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) supplying random leaf labels.
module oram_lfsr #(
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int          OUT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    output logic [OUT_W-1:0] value
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Next-state: right-shift with feedback taps when enabled.
    always_comb begin
        if (en) begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // LFSR state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/oram_path_responder.sv
// Path-ORAM responder: one block access per request, fixed 2L+5 cycle latency,
// Z=1 bucket tree, register stash, position map and LFSR remapping.
module oram_path_responder
    import oram_pkg::*;
#(
    parameter int          D              = 10,
    parameter int          L              = D,
    parameter int          BYTE_WIDTH     = 8,
    parameter int          BYTES_PER_WORD = 4,
    parameter int          STASH_SIZE     = 16,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1,
    localparam int         WORD_WIDTH     = BYTE_WIDTH * BYTES_PER_WORD
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [D-1:0]          rw_block_number,
    input  logic [WORD_WIDTH-1:0] w_value,
    input  logic                  rw_indicator,
    input  logic                  input_ready,
    output logic [WORD_WIDTH-1:0] r_value,
    output logic                  output_ready,
    output logic                  busy,
    output logic                  stash_overflow
);

    localparam int NB       = 2 ** (L + 1) - 1;
    localparam int PM_N     = 2 ** D;
    localparam int INIT_LEN = (NB > PM_N) ? NB : PM_N;
    localparam int AW       = L + 1;
    localparam int CW       = $clog2(INIT_LEN);
    localparam int LVW      = $clog2(L + 2);

    typedef struct packed {
        logic                  valid;
        logic [D-1:0]          blk;
        logic [L-1:0]          leaf;
        logic [WORD_WIDTH-1:0] data;
    } bucket_t;
    typedef bucket_t stash_t;

    state_e                state_q, state_d;
    logic [CW-1:0]         init_q, init_d;
    logic [LVW-1:0]        lvl_q, lvl_d, rd_lvl;
    logic [D-1:0]          blk_q, blk_d;
    logic [WORD_WIDTH-1:0] wdata_q, wdata_d, result_q, result_d, r_value_q, r_value_d;
    logic                  wr_q, wr_d, output_ready_q, output_ready_d;
    logic                  busy_q, busy_d, overflow_q, overflow_d;
    logic [L-1:0]          old_leaf_q, old_leaf_d, new_leaf_q, new_leaf_d, lfsr_leaf;
    stash_t                stash_q [STASH_SIZE];
    stash_t                stash_d [STASH_SIZE];

    bucket_t               bucket_mem [NB];
    logic [L-1:0]          posmap_mem [PM_N];
    bucket_t               bkt_rdata_q, bkt_wdata, ins_entry;
    logic [AW-1:0]         bkt_waddr, bkt_raddr, rd_addr, ev_addr;
    logic [D-1:0]          pm_waddr, pm_raddr;
    logic [L-1:0]          pm_wdata, pm_rdata_q;
    logic                  bkt_we, pm_we, lfsr_en, ins_req;
    logic                  hit, elig, match_found, free_found, evict_found;
    int                    match_idx, free_idx, evict_idx;

    oram_lfsr #(.SEED(LFSR_SEED), .OUT_W(L)) u_lfsr (
        .clock (clock),
        .reset (reset),
        .en    (lfsr_en),
        .value (lfsr_leaf)
    );

    // Bucket tree and position map: one write and one registered read per cycle.
    always_ff @(posedge clock) begin
        if (bkt_we) begin
            bucket_mem[bkt_waddr] <= bkt_wdata;
        end
        bkt_rdata_q <= bucket_mem[bkt_raddr];
        if (pm_we) begin
            posmap_mem[pm_waddr] <= pm_wdata;
        end
        pm_rdata_q <= posmap_mem[pm_raddr];
    end

    // Path addresses and lowest-index priority searches over the stash.
    always_comb begin
        match_found = 1'b0;
        match_idx   = 0;
        free_found  = 1'b0;
        free_idx    = 0;
        evict_found = 1'b0;
        evict_idx   = 0;
        hit         = 1'b0;
        elig        = 1'b0;
        rd_lvl      = (lvl_q < LVW'(L)) ? lvl_q + LVW'(1'b1) : LVW'(L);
        rd_addr     = AW'(path_node(32'(old_leaf_q), int'(rd_lvl), L) - 32'd1);
        ev_addr     = AW'(path_node(32'(old_leaf_q), int'(lvl_q), L) - 32'd1);
        for (int i = STASH_SIZE - 1; i >= 0; i--) begin
            hit         = stash_q[i].valid && (stash_q[i].blk == blk_q);
            elig        = stash_q[i].valid &&
                          on_path(32'(stash_q[i].leaf), 32'(old_leaf_q), int'(lvl_q), L);
            match_idx   = hit ? i : match_idx;
            match_found = match_found | hit;
            evict_idx   = elig ? i : evict_idx;
            evict_found = evict_found | elig;
            free_idx    = stash_q[i].valid ? free_idx : i;
            free_found  = free_found | !stash_q[i].valid;
        end
    end

    // Request FSM: next state, memory commands and stash updates.
    always_comb begin
        state_d        = state_q;
        init_d         = init_q;
        lvl_d          = lvl_q;
        blk_d          = blk_q;
        wdata_d        = wdata_q;
        wr_d           = wr_q;
        old_leaf_d     = old_leaf_q;
        new_leaf_d     = new_leaf_q;
        result_d       = result_q;
        r_value_d      = r_value_q;
        output_ready_d = 1'b0;
        busy_d         = busy_q;
        overflow_d     = overflow_q;
        stash_d        = stash_q;
        lfsr_en        = 1'b0;
        bkt_we         = 1'b0;
        bkt_waddr      = '0;
        bkt_wdata      = '0;
        bkt_raddr      = '0;
        pm_we          = 1'b0;
        pm_waddr       = '0;
        pm_wdata       = '0;
        pm_raddr       = blk_q;
        ins_req        = 1'b0;
        ins_entry      = '0;
        case (state_q)
            ST_INIT: begin
                lfsr_en   = 1'b1;
                bkt_we    = int'(init_q) < NB;
                bkt_waddr = AW'(init_q);
                pm_we     = int'(init_q) < PM_N;
                pm_waddr  = D'(init_q);
                pm_wdata  = lfsr_leaf;
                if (init_q == CW'(INIT_LEN - 1)) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    init_d = init_q + CW'(1'b1);
                end
            end
            ST_IDLE: begin
                pm_raddr = rw_block_number;
                if (input_ready && !busy_q) begin
                    blk_d   = rw_block_number;
                    wdata_d = w_value;
                    wr_d    = rw_indicator;
                    busy_d  = 1'b1;
                    state_d = ST_POS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_POS: begin
                old_leaf_d = pm_rdata_q;
                new_leaf_d = lfsr_leaf;
                pm_we      = 1'b1;
                pm_waddr   = blk_q;
                pm_wdata   = lfsr_leaf;
                lfsr_en    = 1'b1;
                lvl_d      = '0;
                state_d    = ST_READ;
            end
            ST_READ: begin
                // Data for level lvl_q arrives now; the next level's read is issued alongside.
                ins_req   = bkt_rdata_q.valid;
                ins_entry = bkt_rdata_q;
                bkt_raddr = rd_addr;
                if (lvl_q == LVW'(L)) begin
                    state_d = ST_ACCESS;
                end else begin
                    lvl_d = lvl_q + LVW'(1'b1);
                end
            end
            ST_ACCESS: begin
                result_d = match_found ? stash_q[match_idx].data : '0;
                if (match_found) begin
                    stash_d[match_idx].leaf = new_leaf_q;
                    stash_d[match_idx].data = wr_q ? wdata_q : stash_q[match_idx].data;
                end else begin
                    ins_req         = wr_q;
                    ins_entry.valid = 1'b1;
                    ins_entry.blk   = blk_q;
                    ins_entry.leaf  = new_leaf_q;
                    ins_entry.data  = wdata_q;
                end
                state_d = ST_EVICT;
            end
            ST_EVICT: begin
                bkt_we    = 1'b1;
                bkt_waddr = ev_addr;
                if (evict_found) begin
                    bkt_wdata                = stash_q[evict_idx];
                    stash_d[evict_idx].valid = 1'b0;
                end else begin
                    bkt_wdata = '0;
                end
                if (lvl_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    lvl_d = lvl_q - LVW'(1'b1);
                end
            end
            ST_RESP: begin
                output_ready_d = 1'b1;
                r_value_d      = result_q;
                busy_d         = 1'b0;
                state_d        = ST_IDLE;
            end
            default: begin
                state_d = ST_INIT;
                init_d  = '0;
                busy_d  = 1'b1;
            end
        endcase
        // A block that finds no free slot is dropped and the overflow flag sticks.
        if (ins_req && free_found) begin
            stash_d[free_idx] = ins_entry;
        end else begin
            overflow_d = overflow_q | ins_req;
        end
    end

    // Control, datapath and stash registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= ST_INIT;
            init_q         <= '0;
            lvl_q          <= '0;
            blk_q          <= '0;
            wdata_q        <= '0;
            wr_q           <= 1'b0;
            old_leaf_q     <= '0;
            new_leaf_q     <= '0;
            result_q       <= '0;
            r_value_q      <= '0;
            output_ready_q <= 1'b0;
            busy_q         <= 1'b1;
            overflow_q     <= 1'b0;
            for (int i = 0; i < STASH_SIZE; i++) begin
                stash_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            init_q         <= init_d;
            lvl_q          <= lvl_d;
            blk_q          <= blk_d;
            wdata_q        <= wdata_d;
            wr_q           <= wr_d;
            old_leaf_q     <= old_leaf_d;
            new_leaf_q     <= new_leaf_d;
            result_q       <= result_d;
            r_value_q      <= r_value_d;
            output_ready_q <= output_ready_d;
            busy_q         <= busy_d;
            overflow_q     <= overflow_d;
            for (int i = 0; i < STASH_SIZE; i++) begin
                stash_q[i] <= stash_d[i];
            end
        end
    end

    assign r_value        = r_value_q;
    assign output_ready   = output_ready_q;
    assign busy           = busy_q;
    assign stash_overflow = overflow_q;

endmodule
